// File: rtl/slice_pkg.sv
// Shared types for the slice unpacker: serializer states and
// lane-counter sizing helper.
package slice_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Counter width for a given lane count, never narrower than one bit.
    function automatic int cnt_w(input int lanes);
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/slice_unpacker_if.sv
// Word-in / lane-out handshake bundle for the slice unpacker.
interface slice_unpacker_if #(
    parameter int WIDTH = 16,
    parameter int LANE  = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [LANE-1:0]  out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/slice_fifo2.sv
// Two-entry word buffer with 1-bit wrap pointers and a 2-bit
// occupancy count; pushes while full are dropped.
module slice_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/slice_unpacker.sv
// Serializes buffered WIDTH-bit words into LANE-bit lanes, one per
// cycle, with a registered output stage and back-to-back word reload.
module slice_unpacker
    import slice_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 8,
    parameter int SWAP  = 1
) (
    input  logic       CLK,
    input  logic       ASYNCRESET,
    slice_unpacker_if.slave bus
);
    localparam int N  = WIDTH / LANE;
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LANE-1:0]  dat_q, dat_d;
    logic             last_q, last_d;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;

    function automatic logic [LANE-1:0] lane_of(input logic [WIDTH-1:0] w);
        return (SWAP != 0) ? w[LANE-1:0] : w[WIDTH-1 -: LANE];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (SWAP != 0) ? (w >> LANE) : (w << LANE);
    endfunction

    slice_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .push_i     (bus.in_valid),
        .pop_i      (pop),
        .data_i     (bus.in_data),
        .data_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign bus.in_ready  = !full;
    assign bus.out_data  = dat_q;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_last  = last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                    sh_d    = head;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (cnt_q != LAST) begin
                        cnt_d = cnt_q + CW'(1);
                        sh_d  = advance(sh_q);
                    end else if (!empty) begin
                        // Reload on the final lane so words stream without a bubble.
                        pop   = 1'b1;
                        sh_d  = head;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
        dat_d  = lane_of(sh_d);
        last_d = (state_d == SEND) && (cnt_d == LAST);
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dat_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_slice_unpacker.sv
// Directed per-cycle vectors for three unpacker configurations plus a
// hand-written mid-word reset sequence.
module tb_slice_unpacker;
    logic CLK = 1'b0;
    logic ASYNCRESET = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    slice_unpacker_if #(.WIDTH(16), .LANE(8)) ifa ();
    slice_unpacker_if #(.WIDTH(16), .LANE(8)) ifb ();
    slice_unpacker_if #(.WIDTH(32), .LANE(8)) ifc ();

    slice_unpacker #(.WIDTH(16), .LANE(8), .SWAP(1)) u_a (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(ifa.slave));
    slice_unpacker #(.WIDTH(16), .LANE(8), .SWAP(0)) u_b (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(ifb.slave));
    slice_unpacker #(.WIDTH(32), .LANE(8), .SWAP(1)) u_c (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(ifc.slave));

    typedef struct {
        int          sel;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        eir;
        logic        eov;
        logic [7:0]  eod;
        logic        eol;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int sel, input logic iv,
                                input logic [31:0] id, input logic ordy,
                                input logic eir, input logic eov,
                                input logic [7:0] eod, input logic eol);
        vec_t v;
        v.sel = sel; v.iv = iv; v.id = id; v.ordy = ordy;
        v.eir = eir; v.eov = eov; v.eod = eod; v.eol = eol;
        vecs.push_back(v);
    endfunction

    task automatic drive(input int sel, input logic iv,
                         input logic [31:0] id, input logic ordy);
        ifa.in_valid  = (sel == 0) && iv;
        ifa.in_data   = id[15:0];
        ifa.out_ready = (sel == 0) ? ordy : 1'b1;
        ifb.in_valid  = (sel == 1) && iv;
        ifb.in_data   = id[15:0];
        ifb.out_ready = (sel == 1) ? ordy : 1'b1;
        ifc.in_valid  = (sel == 2) && iv;
        ifc.in_data   = id;
        ifc.out_ready = (sel == 2) ? ordy : 1'b1;
    endtask

    function automatic logic [10:0] sample(input int sel);
        case (sel)
            0:       return {ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.out_last};
            1:       return {ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.out_last};
            default: return {ifc.in_ready, ifc.out_valid, ifc.out_data, ifc.out_last};
        endcase
    endfunction

    task automatic check(input string nm, input logic [10:0] act,
                         input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got ir/ov/od/ol=%b/%b/%h/%b want %b/%b/%h/%b",
                     nm, act[10], act[9], act[8:1], act[0],
                     exp[10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    // Outputs are checked at the falling edge, then the next inputs are driven.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            logic [10:0] act;
            logic [10:0] exp;
            @(negedge CLK);
            act = sample(vecs[i].sel);
            exp = {vecs[i].eir, vecs[i].eov, vecs[i].eod, vecs[i].eol};
            if (!vecs[i].eov) begin
                act[8:1] = 8'h00;
                exp[8:1] = 8'h00;
            end
            check($sformatf("vec%0d", i), act, exp);
            drive(vecs[i].sel, vecs[i].iv, vecs[i].id, vecs[i].ordy);
        end
    endtask

    int split;

    initial begin
        // SWAP=1 basic
        add(0, 1, 32'hA1B2, 1, 1, 0, 8'h00, 0);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'hB2, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'hA1, 1);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        // SWAP=0 basic
        add(1, 1, 32'hA1B2, 1, 1, 0, 8'h00, 0);
        add(1, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        add(1, 0, 32'h0,    1, 1, 1, 8'hA1, 0);
        add(1, 0, 32'h0,    1, 1, 1, 8'hB2, 1);
        add(1, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        // back-to-back streaming
        add(0, 1, 32'h1122, 1, 1, 0, 8'h00, 0);
        add(0, 1, 32'h3344, 1, 1, 0, 8'h00, 0);
        add(0, 1, 32'h5566, 1, 1, 1, 8'h22, 0);
        add(0, 0, 32'h0,    1, 0, 1, 8'h11, 1);
        add(0, 0, 32'h0,    1, 1, 1, 8'h44, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'h33, 1);
        add(0, 0, 32'h0,    1, 1, 1, 8'h66, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'h55, 1);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        // backpressure, full FIFO, dropped push of 0x0004
        add(0, 1, 32'h0001, 0, 1, 0, 8'h00, 0);
        add(0, 1, 32'h0002, 0, 1, 0, 8'h00, 0);
        add(0, 1, 32'h0003, 0, 1, 1, 8'h01, 0);
        add(0, 1, 32'h0004, 0, 0, 1, 8'h01, 0);
        add(0, 0, 32'h0,    0, 0, 1, 8'h01, 0);
        add(0, 0, 32'h0,    1, 0, 1, 8'h01, 0);
        add(0, 0, 32'h0,    1, 0, 1, 8'h00, 1);
        add(0, 0, 32'h0,    1, 1, 1, 8'h02, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'h00, 1);
        add(0, 0, 32'h0,    1, 1, 1, 8'h03, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'h00, 1);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        // 32-bit word, four lanes
        add(2, 1, 32'hDEADBEEF, 1, 1, 0, 8'h00, 0);
        add(2, 0, 32'h0,        1, 1, 0, 8'h00, 0);
        add(2, 0, 32'h0,        1, 1, 1, 8'hEF, 0);
        add(2, 0, 32'h0,        1, 1, 1, 8'hBE, 0);
        add(2, 0, 32'h0,        1, 1, 1, 8'hAD, 0);
        add(2, 0, 32'h0,        1, 1, 1, 8'hDE, 1);
        add(2, 0, 32'h0,        1, 1, 0, 8'h00, 0);
        split = vecs.size();
        // after mid-word reset: new word only
        add(0, 1, 32'h1234, 1, 1, 0, 8'h00, 0);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'h34, 0);
        add(0, 0, 32'h0,    1, 1, 1, 8'h12, 1);
        add(0, 0, 32'h0,    1, 1, 0, 8'h00, 0);

        drive(0, 0, 32'h0, 1);
        #1 ASYNCRESET = 1'b1;
        #1;
        check("rst_a", sample(0), 11'b1_0_00000000_0);
        check("rst_b", sample(1), 11'b1_0_00000000_0);
        check("rst_c", sample(2), 11'b1_0_00000000_0);
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #2 ASYNCRESET = 1'b0;

        run(0, split);

        // Mid-word reset while lane 0xEF is stalled
        @(negedge CLK);
        drive(0, 1, 32'hBEEF, 0);
        @(negedge CLK);
        drive(0, 0, 32'h0, 0);
        @(negedge CLK);
        check("midrst_pre", sample(0), {1'b1, 1'b1, 8'hEF, 1'b0});
        #2 ASYNCRESET = 1'b1;
        #1;
        check("midrst_async", sample(0), 11'b1_0_00000000_0);
        drive(0, 0, 32'h0, 1);
        @(posedge CLK);
        #2 ASYNCRESET = 1'b0;

        run(split, vecs.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slice_unpacker.md
SLICE_UNPACKER -- requirements
Module: slice_unpacker

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input word width in bits.
REQ-002 SHALL have parameter LANE, default 8: output lane width in bits; WIDTH is an integer multiple of LANE, with at least 2 lanes.
REQ-003 SHALL have parameter SWAP, default 1: 1 = lowest lane (bits LANE-1:0) emitted first; 0 = highest lane emitted first.
REQ-004 SHALL have the following ports: one clock; reset is asynchronous and active-high.
- CLK  input  1  rising-edge clock
- ASYNCRESET  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  word to serialize
- in_valid  input  1  in_data valid
- in_ready  output  1  word accepted when in_valid && in_ready at a CLK edge
- out_data  output  LANE  current lane
- out_valid  output  1  out_data valid
- out_ready  input  1  lane consumed when out_valid && out_ready at a CLK edge
- out_last  output  1  final lane of the current word, qualified by out_valid

Function
REQ-005 SHALL buffer accepted words in a 2-entry FIFO; in_ready = FIFO not full (registered, no combinational path from out_ready).
REQ-006 SHALL run serializer FSM states IDLE and SEND.
- IDLE->SEND: FIFO non-empty; pops head into shift register, lane count = 0.
- SEND->SEND: lane handshake on a non-last lane; count+1.
- SEND->SEND: lane handshake on last lane with FIFO non-empty; next word popped the same edge (no bubble).
- SEND->IDLE: lane handshake on last lane with FIFO empty.
REQ-007 SHALL register out_data, out_valid and out_last; out_valid = (state == SEND).
REQ-008 SHALL assert out_last exactly when lane count = WIDTH/LANE-1.
REQ-009 SHALL give latency of one cycle: a word accepted at edge N into an empty FIFO with the FSM in IDLE presents its first lane after edge N+1.
REQ-010 SHALL sustain one lane per cycle while out_ready is held high and words are available.
REQ-011 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-012 SHALL accept a push and perform a pop on the same edge when the FIFO is non-full; occupancy is unchanged.
REQ-013 SHALL ignore in_valid when full; in_data is not captured and in_ready stays low until a pop.
REQ-014 SHALL implement FIFO pointers as 1-bit wrap-around, with full/empty from a 2-bit occupancy count.

Reset
REQ-015 SHALL, on ASYNCRESET high, immediately force: state IDLE, occupancy 0, lane count 0, out_valid 0, out_last 0, out_data 0, in_ready 1.
REQ-016 SHALL drop all buffered words and any partially sent word when reset is asserted mid-operation; no lanes are emitted after release until a new word is accepted.
REQ-017 SHALL resume accepting words on the first CLK edge after ASYNCRESET deasserts.

Structure
REQ-018 SHALL place the FSM state enum (IDLE, SEND) and a lane-count width constant function in shared package slice_pkg.
REQ-019 SHALL implement the buffer as sub-module slice_fifo2 (parameter WIDTH; CLK, ASYNCRESET, push/pop/full/empty); serializer logic stays in slice_unpacker.

Verification
REQ-020 SHALL cover basic SWAP=1: push 0xA1B2 with out_ready=1 -> out_data 0xB2 (out_last=0) then 0xA1 (out_last=1) on consecutive cycles, first lane one cycle after accept.
REQ-021 SHALL cover SWAP=0: push 0xA1B2 -> 0xA1 then 0xB2 (out_last on 0xB2).
REQ-022 SHALL cover back-to-back streaming: push 0x1122, 0x3344, 0x5566 with out_ready=1 -> 0x22,0x11,0x44,0x33,0x66,0x55 with no gap in out_valid.
REQ-023 SHALL cover backpressure/full: out_ready=0, push 0x0001, 0x0002, 0x0003 -> in_ready low once FIFO holds 0x0002 and 0x0003; 0x0004 offered while full is not captured; after releasing out_ready -> 0x01,0x00,0x02,0x00,0x03,0x00; outputs stable while stalled.
REQ-024 SHALL cover mid-word reset: push 0xBEEF, assert ASYNCRESET after lane 0xEF -> out_valid 0 immediately, 0xBE never appears; after release, push 0x1234 -> 0x34, 0x12.
REQ-025 SHALL cover a WIDTH=32, LANE=8 configuration: push 0xDEADBEEF, SWAP=1 -> 0xEF,0xBE,0xAD,0xDE, with out_last only on 0xDE.
